// File: rtl/vfpu_ctrl_fsm.sv
// Control FSM that sequences two source streamers and one sink streamer for a vector add/sub job.
// Optional watchdog: define VFPU_CTRL_TIMEOUT_EN to bound the WAIT_READY and RUN states.
module vfpu_ctrl_fsm #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic                    op_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    input  logic [ADDR_WIDTH-1:0]   addr_a_i,
    input  logic [ADDR_WIDTH-1:0]   addr_b_i,
    input  logic [ADDR_WIDTH-1:0]   addr_c_i,
    input  logic [1:0]              src_ready_i,
    input  logic [1:0]              src_done_i,
    input  logic                    sink_ready_i,
    input  logic                    sink_done_i,
    output logic [1:0]              src_req_start_o,
    output logic                    sink_req_start_o,
    output logic [2*ADDR_WIDTH-1:0] src_addr_o,
    output logic [ADDR_WIDTH-1:0]   sink_addr_o,
    output logic [LEN_WIDTH-1:0]    trans_size_o,
    output logic                    op_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        START,
        RUN,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic                    op_q, op_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
    logic [ADDR_WIDTH-1:0]   addr_c_q, addr_c_d;
    logic [1:0]              src_done_q, src_done_d;
    logic                    sink_done_q, sink_done_d;
    logic                    error_q, error_d;

`ifdef VFPU_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        addr_c_d    = addr_c_q;
        src_done_d  = src_done_q;
        sink_done_d = sink_done_q;
        error_d     = error_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        op_d     = op_i;
                        len_d    = len_i;
                        addr_a_d = addr_a_i;
                        addr_b_d = addr_b_i;
                        addr_c_d = addr_c_i;
                        error_d  = 1'b0;
                        state_d  = WAIT_READY;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            WAIT_READY: begin
                if (src_ready_i == 2'b11 && sink_ready_i) state_d = START;
            end
            START: state_d = RUN;
            RUN: begin
                src_done_d  = src_done_q | src_done_i;
                sink_done_d = sink_done_q | sink_done_i;
                // Same-cycle source dones count as recorded before the sink done.
                if (sink_done_d) begin
                    if (src_done_d != 2'b11) error_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                src_done_d  = '0;
                sink_done_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef VFPU_CTRL_TIMEOUT_EN
        if ((state_q == WAIT_READY || state_q == RUN) && cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            error_d = 1'b1;
            state_d = DONE;
        end
        // Counter restarts from zero on every state entry.
        cnt_d = '0;
        if (state_d == state_q && (state_q == WAIT_READY || state_q == RUN))
            cnt_d = cnt_q + CNT_W'(1);
`endif

        if (clear_i) begin
            state_d     = IDLE;
            op_d        = 1'b0;
            len_d       = '0;
            addr_a_d    = '0;
            addr_b_d    = '0;
            addr_c_d    = '0;
            src_done_d  = '0;
            sink_done_d = 1'b0;
            error_d     = 1'b0;
`ifdef VFPU_CTRL_TIMEOUT_EN
            cnt_d       = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            len_q       <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_c_q    <= '0;
            src_done_q  <= '0;
            sink_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            addr_c_q    <= addr_c_d;
            src_done_q  <= src_done_d;
            sink_done_q <= sink_done_d;
            error_q     <= error_d;
        end
    end

`ifdef VFPU_CTRL_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`endif

    assign src_req_start_o  = (state_q == START) ? 2'b11 : 2'b00;
    assign sink_req_start_o = (state_q == START);
    assign src_addr_o       = {addr_b_q, addr_a_q};
    assign sink_addr_o      = addr_c_q;
    assign trans_size_o     = len_q;
    assign op_o             = op_q;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);
    assign error_o          = error_q;

endmodule

// File: tb/tb_vfpu_ctrl_fsm.sv
// Directed, table-driven bench for vfpu_ctrl_fsm (default build, watchdog disabled).
module tb_vfpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear, start, op;
    logic [15:0] len;
    logic [31:0] addr_a, addr_b, addr_c;
    logic [1:0]  src_ready, src_done;
    logic        sink_ready, sink_done;
    logic [1:0]  src_req;
    logic        sink_req;
    logic [63:0] src_addr;
    logic [31:0] sink_addr;
    logic [15:0] trans_size;
    logic        op_out, busy, done, error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vfpu_ctrl_fsm #(.ADDR_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT_CYCLES(65535)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .op_i(op),
        .len_i(len), .addr_a_i(addr_a), .addr_b_i(addr_b), .addr_c_i(addr_c),
        .src_ready_i(src_ready), .src_done_i(src_done),
        .sink_ready_i(sink_ready), .sink_done_i(sink_done),
        .src_req_start_o(src_req), .sink_req_start_o(sink_req),
        .src_addr_o(src_addr), .sink_addr_o(sink_addr), .trans_size_o(trans_size),
        .op_o(op_out), .busy_o(busy), .done_o(done), .error_o(error)
    );

    typedef struct packed {
        logic [1:0]  srq;
        logic        krq;
        logic        busy;
        logic        done;
        logic        err;
        logic [15:0] len;
        logic        op;
        logic [31:0] b;
        logic [31:0] a;
        logic [31:0] c;
    } outs_t;

    typedef struct {
        logic        st, op, krdy, kdn, clr;
        logic [15:0] len;
        logic [31:0] a, b, c;
        logic [1:0]  srdy, sdn;
        int          reps;
        outs_t       exp;
    } vec_t;

    vec_t vecs[$];

    function automatic outs_t o(input logic [1:0] srq, input logic krq, bsy, dn, er,
                                input logic [15:0] l, input logic opv,
                                input logic [31:0] a, b, c);
        o = '{srq: srq, krq: krq, busy: bsy, done: dn, err: er, len: l, op: opv, b: b, a: a, c: c};
    endfunction

    function automatic vec_t v(input logic st, opv, input logic [15:0] l,
                               input logic [31:0] a, b, c, input logic [1:0] srdy, sdn,
                               input logic krdy, kdn, clr, input int reps, input outs_t e);
        v = '{st: st, op: opv, krdy: krdy, kdn: kdn, clr: clr, len: l, a: a, b: b, c: c,
              srdy: srdy, sdn: sdn, reps: reps, exp: e};
    endfunction

    function automatic outs_t got();
        got = '{srq: src_req, krq: sink_req, busy: busy, done: done, err: error,
                len: trans_size, op: op_out, b: src_addr[63:32], a: src_addr[31:0], c: sink_addr};
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t g;
        g = got();
        checks++;
        if (g !== exp) begin
            errors++;
            $display("FAIL %s: got srq=%b krq=%b busy=%b done=%b err=%b len=%0d op=%b a=%h b=%h c=%h; want srq=%b krq=%b busy=%b done=%b err=%b len=%0d op=%b a=%h b=%h c=%h",
                     name, g.srq, g.krq, g.busy, g.done, g.err, g.len, g.op, g.a, g.b, g.c,
                     exp.srq, exp.krq, exp.busy, exp.done, exp.err, exp.len, exp.op, exp.a, exp.b, exp.c);
        end
    endtask

    task automatic idle_inputs();
        start = 0; op = 0; len = '0; addr_a = '0; addr_b = '0; addr_c = '0;
        src_ready = '0; src_done = '0; sink_ready = 0; sink_done = 0; clear = 0;
    endtask

    outs_t Z, L1, L2, L3, L4;

    initial begin
        rst_n = 0;
        idle_inputs();

        Z  = o(2'b00, 0, 0, 0, 0, 16'd0,  0, 32'h0,    32'h0,    32'h0);
        L1 = o(2'b00, 0, 0, 0, 0, 16'd16, 0, 32'h100,  32'h200,  32'h300);
        L2 = o(2'b00, 0, 0, 0, 0, 16'd4,  1, 32'h10,   32'h20,   32'h30);
        L3 = o(2'b00, 0, 0, 0, 0, 16'd2,  0, 32'h1000, 32'h2000, 32'h3000);
        L4 = o(2'b00, 0, 0, 0, 0, 16'd7,  1, 32'h4,    32'h8,    32'hC);

        // Job 1: nominal, start at T, pulses at T+2, sink done at T+20, done_o at T+21
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 2, Z));
        vecs.push_back(v(1,0,16,32'h100,32'h200,32'h300,2'b11,2'b00,1,0,0, 1, Z));
        vecs.push_back(v(0,0,0,0,0,0,2'b11,2'b00,1,0,0, 1, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:16, op:0, b:32'h200, a:32'h100, c:32'h300}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 1, '{srq:2'b11, krq:1, busy:1, done:0, err:0, len:16, op:0, b:32'h200, a:32'h100, c:32'h300}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 7, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:16, op:0, b:32'h200, a:32'h100, c:32'h300}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b11,0,0,0, 1, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:16, op:0, b:32'h200, a:32'h100, c:32'h300}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 9, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:16, op:0, b:32'h200, a:32'h100, c:32'h300}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,1,0, 1, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:16, op:0, b:32'h200, a:32'h100, c:32'h300}));
        vecs.push_back(v(1,1,5,32'h1,32'h2,32'h3,2'b11,2'b00,1,0,0, 1, '{srq:2'b00, krq:0, busy:1, done:1, err:0, len:16, op:0, b:32'h200, a:32'h100, c:32'h300}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 1, L1));
        // Zero-length start flags error, next good start clears it; sink held not-ready
        vecs.push_back(v(1,1,0,32'hAAA,32'hBBB,32'hCCC,2'b11,2'b00,1,0,0, 1, L1));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 1, '{srq:2'b00, krq:0, busy:0, done:0, err:1, len:16, op:0, b:32'h200, a:32'h100, c:32'h300}));
        vecs.push_back(v(1,1,4,32'h10,32'h20,32'h30,2'b11,2'b00,0,0,0, 1, '{srq:2'b00, krq:0, busy:0, done:0, err:1, len:16, op:0, b:32'h200, a:32'h100, c:32'h300}));
        vecs.push_back(v(0,0,0,0,0,0,2'b11,2'b00,0,0,0, 10, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:4, op:1, b:32'h20, a:32'h10, c:32'h30}));
        vecs.push_back(v(0,0,0,0,0,0,2'b11,2'b00,1,0,0, 1, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:4, op:1, b:32'h20, a:32'h10, c:32'h30}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 1, '{srq:2'b11, krq:1, busy:1, done:0, err:0, len:4, op:1, b:32'h20, a:32'h10, c:32'h30}));
        // Sink done with only source 0 done: error, still completes
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b01,0,0,0, 1, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:4, op:1, b:32'h20, a:32'h10, c:32'h30}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,1,0, 1, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:4, op:1, b:32'h20, a:32'h10, c:32'h30}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 1, '{srq:2'b00, krq:0, busy:1, done:1, err:1, len:4, op:1, b:32'h20, a:32'h10, c:32'h30}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 1, '{srq:2'b00, krq:0, busy:0, done:0, err:1, len:4, op:1, b:32'h20, a:32'h10, c:32'h30}));
        // Job 3: start ignored while busy; all dones in the same cycle is not an error
        vecs.push_back(v(1,0,2,32'h1000,32'h2000,32'h3000,2'b11,2'b00,1,0,0, 1, '{srq:2'b00, krq:0, busy:0, done:0, err:1, len:4, op:1, b:32'h20, a:32'h10, c:32'h30}));
        vecs.push_back(v(0,0,0,0,0,0,2'b11,2'b00,1,0,0, 1, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:2, op:0, b:32'h2000, a:32'h1000, c:32'h3000}));
        vecs.push_back(v(1,1,9,32'h9,32'h9,32'h9,2'b11,2'b00,1,0,0, 1, '{srq:2'b11, krq:1, busy:1, done:0, err:0, len:2, op:0, b:32'h2000, a:32'h1000, c:32'h3000}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b11,0,1,0, 1, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:2, op:0, b:32'h2000, a:32'h1000, c:32'h3000}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 1, '{srq:2'b00, krq:0, busy:1, done:1, err:0, len:2, op:0, b:32'h2000, a:32'h1000, c:32'h3000}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 1, L3));
        // Soft clear aborts a pending job and wipes latched values and error
        vecs.push_back(v(1,1,7,32'h4,32'h8,32'hC,2'b00,2'b00,0,0,0, 1, L3));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,1, 1, '{srq:2'b00, krq:0, busy:1, done:0, err:0, len:7, op:1, b:32'h8, a:32'h4, c:32'hC}));
        vecs.push_back(v(0,0,0,0,0,0,2'b11,2'b00,1,1,0, 2, Z));
        vecs.push_back(v(1,0,0,0,0,0,2'b00,2'b00,0,0,0, 1, Z));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,1, 1, '{srq:2'b00, krq:0, busy:0, done:0, err:1, len:0, op:0, b:0, a:0, c:0}));
        vecs.push_back(v(0,0,0,0,0,0,2'b00,2'b00,0,0,0, 1, Z));

        if (L2.len != 16'd4 || L4.len != 16'd7) $display("note: job constants altered");

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                start = vecs[i].st; op = vecs[i].op; len = vecs[i].len;
                addr_a = vecs[i].a; addr_b = vecs[i].b; addr_c = vecs[i].c;
                src_ready = vecs[i].srdy; src_done = vecs[i].sdn;
                sink_ready = vecs[i].krdy; sink_done = vecs[i].kdn; clear = vecs[i].clr;
                @(negedge clk);
                check($sformatf("vec%0d_rep%0d", i, r), vecs[i].exp);
                @(posedge clk); #1;
            end
        end
        idle_inputs();

        // Asynchronous reset in RUN: outputs drop immediately, no done after release
        begin
            bit seen_start;
            seen_start = 0;
            start = 1; len = 16'd3; op = 1; addr_a = 32'h40; addr_b = 32'h50; addr_c = 32'h60;
            src_ready = 2'b11; sink_ready = 1;
            @(posedge clk); #1;
            idle_inputs();
            src_ready = 2'b11; sink_ready = 1;
            for (int k = 0; k < 5 && !seen_start; k++) begin
                @(negedge clk);
                if (src_req == 2'b11) seen_start = 1;
            end
            checks++;
            if (!seen_start) begin
                errors++;
                $display("FAIL rst_start_pulse: got no start pulse within 5 cycles, want one");
            end
            @(posedge clk); #1;
            check("rst_in_run_busy", o(2'b00, 0, 1, 0, 0, 16'd3, 1, 32'h40, 32'h50, 32'h60));
            #2 rst_n = 0;
            #1 check("rst_async_zero", Z);
            @(negedge clk);
            rst_n = 1;
            sink_done = 1; src_done = 2'b11;
            @(posedge clk); #1;
            idle_inputs();
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check($sformatf("post_rst_idle%0d", k), Z);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout at %0t, want bench completion", $time);
        $fatal(1);
    end

endmodule
